divide32_seq: RTL and testbench

//  Iterative restoring divider; the inverse counterpart of the Booth multiplier in the ALU datapath.

---
 rtl/divide32_seq_pkg.sv | 18 +
 rtl/divide32_seq_step.sv | 27 ++
 rtl/divide32_seq.sv | 132 +++++++++++++
 tb/tb_divide32_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/divide32_seq_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and the HI/LO result packing order.
package divide32_seq_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // HI holds the remainder, LO the quotient: result = {remainder, quotient}.
  localparam int LO_LSB = 0;
  localparam int HI_LSB = DIV_WIDTH;

endpackage

// File: rtl/divide32_seq_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module divide_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] prem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] prem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             step_unused;

  always_comb begin
    shifted = {prem_i, dvd_msb_i};
    trial   = {1'b0, shifted} - {2'b00, dvs_i};
    q_bit_o = ~trial[WIDTH+1];
    // Either branch is below the divisor, so the top bits are always zero.
    prem_o  = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

  assign step_unused = shifted[WIDTH] ^ trial[WIDTH];

endmodule

// File: rtl/divide32_seq.sv
// Iterative restoring divider (DIV/DIVU): one quotient bit per clock, then a
// sign fix-up cycle and a one-cycle done pulse. Result is {remainder, quotient}.
module divide32_seq
  import divide32_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output state_t           dbg_state
);

  // Handshake: start is a request sampled only in IDLE (busy=0); it is neither
  // queued nor re-sampled while busy. done pulses for one cycle and the result
  // stays valid until the next accepted request completes its fix-up.

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_prem;
  logic             step_qbit;

  divide_step #(.WIDTH(WIDTH)) u_step (
    .prem_i    (prem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .prem_o    (step_prem),
    .q_bit_o   (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
          dvs_d   = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
          q_neg_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg_d = signed_op & dividend[WIDTH-1];
          prem_d  = '0;
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        // The dividend register doubles as the quotient accumulator.
        prem_d = step_prem;
        dvd_d  = {dvd_q[WIDTH-2:0], step_qbit};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        dbz_d   = (dvs_q == '0);
        quo_d   = (dvs_q == '0) ? '1 : (q_neg_q ? -dvd_q : dvd_q);
        rem_d   = r_neg_q ? -prem_q : prem_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_divide32_seq.sv
// Self-checking bench for divide32_seq: directed corner cases plus random
// operands compared against a plain-arithmetic reference model.
module tb_divide32_seq;
  import divide32_seq_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  state_t       dbg_state;

  int checks = 0;
  int errors = 0;

  divide32_seq #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder),
    .dbg_state   (dbg_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {remainder, quotient} using the language's own division.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
    chk({tag, "_quo"}, 64'(quotient), 64'd0);
    chk({tag, "_rem"}, 64'(remainder), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(S_IDLE));
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input string tag, input int restart_at, input int abort_at);
    logic [63:0] exp;
    int n;
    int busy_n;
    exp = ref_div(a, b, sgn);
    @(negedge clock);
    dividend  = a;
    divisor   = b;
    signed_op = sgn;
    start     = 1'b1;
    @(posedge clock); #1;
    start  = 1'b0;
    n      = 1;
    busy_n = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) busy_n++;
      dividend  = $urandom;
      divisor   = $urandom;
      signed_op = 1'($urandom_range(0, 1));
      start     = (n == restart_at);
      if (n == abort_at) begin
        start   = 1'b0;
        clear_n = 1'b0;
        #1;
        check_idle_zero({tag, "_abort"});
        @(negedge clock);
        clear_n = 1'b1;
        return;
      end
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'd34);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
    chk({tag, "_quo"}, 64'(quotient), 64'(exp[31:0]));
    chk({tag, "_rem"}, 64'(remainder), 64'(exp[63:32]));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(b == 32'd0));
    @(posedge clock); #1;
    chk({tag, "_done_drop"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_quo_held"}, 64'(quotient), 64'(exp[31:0]));
    chk({tag, "_rem_held"}, 64'(remainder), 64'(exp[63:32]));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    repeat (3) @(posedge clock);
    #1;
    check_idle_zero("reset");
    @(negedge clock);
    clear_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, "u100_7", 0, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, "s_m7_2", 0, 0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, "s_7_m2", 0, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf", 0, 0);
    run_op(32'h0000_1234, 32'd0, 1'b0, "dbz_u", 0, 0);
    run_op(32'hFFFF_EDCC, 32'd0, 1'b1, "dbz_s", 0, 0);
    run_op(32'd50, 32'd5, 1'b0, "after_dbz", 0, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "u_max_1", 0, 0);
    run_op(32'h8000_0000, 32'd1, 1'b1, "s_min_1", 0, 0);
    run_op(32'd3, 32'hFFFF_FFFF, 1'b0, "u_small_big", 0, 0);
    run_op(32'd100, 32'd7, 1'b0, "restart_ign", 10, 0);
    run_op(32'd12345, 32'd17, 1'b1, "abort", 0, 15);
    run_op(32'd12345, 32'd17, 1'b1, "post_abort", 0, 0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 15));
        1: rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(ra, rb, rs, $sformatf("rand%0d", i), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
